// File: rtl/irrigation_sched_if.sv
// Zone request / valve drive bundle for irrigation_sched.
// master = request side (sensor decode), slave = the scheduler.
interface irrigation_sched_if #(
  parameter int N_ZONES = 4
);
  localparam int ZW = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;

  logic [2*N_ZONES-1:0] req;
  logic [1:0]           level;
  logic                 pump_ok;
  logic                 err_clr;
  logic [2*N_ZONES-1:0] valve;
  logic [ZW-1:0]        active_zone;
  logic                 busy;
  logic                 done;
  logic [1:0]           err;

  modport master (
    output req, level, pump_ok, err_clr,
    input  valve, active_zone, busy, done, err
  );

  modport slave (
    input  req, level, pump_ok, err_clr,
    output valve, active_zone, busy, done, err
  );
endinterface

// File: rtl/irrigation_sched.sv
// Round-robin multi-zone irrigation scheduler: timed watering window per grant,
// dead-time gap between grants, tank/pump supervision with a sticky fault code.
module irrigation_sched #(
  parameter int N_ZONES    = 4,
  parameter int ON_CYCLES  = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  irrigation_sched_if.slave  bus
);
  localparam int ZW   = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
  localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_WATER = 2'b01;
  localparam logic [1:0] S_GAP   = 2'b10;
  localparam logic [1:0] S_FAULT = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_EMPTY = 2'b01;
  localparam logic [1:0] ERR_PUMP  = 2'b10;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [1:0]           vmask_q, vmask_d;
  logic [ZW-1:0]        last_zone_q, last_zone_d;
  logic [ZW-1:0]        active_zone_q, active_zone_d;
  logic [2*N_ZONES-1:0] valve_q, valve_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [1:0]           err_q, err_d;

  logic                 found_s;
  logic                 hit_s;
  logic [ZW-1:0]        win_s;
  logic [1:0]           win_req_s;
  int                   idx_s;
  logic                 supply_ok_s;

  function automatic logic [2*N_ZONES-1:0] place_mask(input logic [ZW-1:0] zone,
                                                      input logic [1:0]    mask);
    logic [2*N_ZONES-1:0] v;
    v = '0;
    v[2*zone +: 2] = mask;
    return v;
  endfunction

  assign supply_ok_s = (bus.level >= 2'b10) && bus.pump_ok;

  // Arbiter: scan downward so the last hit is the nearest zone after last_zone.
  always_comb begin
    found_s   = 1'b0;
    hit_s     = 1'b0;
    win_s     = '0;
    win_req_s = 2'b00;
    idx_s     = 0;
    for (int i = N_ZONES; i >= 1; i--) begin
      idx_s     = (int'(last_zone_q) + i) % N_ZONES;
      hit_s     = (bus.req[2*idx_s +: 2] != 2'b00);
      found_s   = found_s | hit_s;
      win_s     = hit_s ? ZW'(idx_s) : win_s;
      win_req_s = hit_s ? bus.req[2*idx_s +: 2] : win_req_s;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    vmask_d       = vmask_q;
    last_zone_d   = last_zone_q;
    active_zone_d = active_zone_q;
    err_d         = err_q;
    valve_d       = '0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (supply_ok_s && found_s) begin
          state_d       = S_WATER;
          vmask_d       = win_req_s;
          active_zone_d = win_s;
          last_zone_d   = win_s;
          timer_d       = ON_LOAD;
          valve_d       = place_mask(win_s, win_req_s);
          busy_d        = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WATER: begin
        if ((bus.level == 2'b00) || !bus.pump_ok) begin
          state_d = S_FAULT;
          err_d   = (bus.level == 2'b00) ? ERR_EMPTY : ERR_PUMP;
        end else if ((bus.req[2*active_zone_q +: 2] == 2'b00) || (timer_q == '0)) begin
          state_d = S_GAP;
          timer_d = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
          valve_d = place_mask(active_zone_q, vmask_q);
          busy_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_FAULT: begin
        if (bus.err_clr && supply_ok_s) begin
          state_d = S_IDLE;
          err_d   = ERR_NONE;
        end else begin
          err_d = err_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset restarts arbitration at zone 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      vmask_q       <= 2'b00;
      last_zone_q   <= ZW'(N_ZONES - 1);
      active_zone_q <= '0;
      valve_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      vmask_q       <= vmask_d;
      last_zone_q   <= last_zone_d;
      active_zone_q <= active_zone_d;
      valve_q       <= valve_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign bus.valve       = valve_q;
  assign bus.active_zone = active_zone_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_irrigation_sched.sv
// Scoreboard bench for irrigation_sched (4 zones, 4-cycle window, 2-cycle gap):
// stimulus queues expected grant/done/fault/clear events, a monitor pops and compares.
module tb_irrigation_sched;
  localparam int EV_GRANT = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_FAULT = 2;
  localparam int EV_CLEAR = 3;

  typedef struct {
    int kind;
    int zone;
    int vf;
    int len;
    int errv;
  } ev_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  ev_t  exp_q[$];

  int   busy_cnt;
  int   idle_cnt;
  logic prev_busy;
  logic [1:0] prev_err;

  irrigation_sched_if #(.N_ZONES(4)) bus_if ();

  irrigation_sched #(.N_ZONES(4), .ON_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input int zone, input int vf, input int len, input int errv);
    ev_t e;
    e.kind = kind; e.zone = zone; e.vf = vf; e.len = len; e.errv = errv;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e.kind = -1; e.zone = 0; e.vf = 0; e.len = -1; e.errv = 0;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d expected=none at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      ok = (kind == e.kind);
    end
  endtask

  task automatic wait_busy(input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.busy && n < maxc);
    chk("wait_busy", bus_if.busy, 1);
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.done && n < maxc);
    chk("wait_done", bus_if.done, 1);
  endtask

  // Monitor: classifies DUT output changes into events and scores them.
  initial begin
    ev_t e;
    bit ok;
    logic [7:0] vexp;
    busy_cnt = 0; idle_cnt = 0; prev_busy = 1'b0; prev_err = 2'b00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cnt = 0; idle_cnt = 0; prev_busy = 1'b0; prev_err = 2'b00;
      end else begin
        if (bus_if.done) begin
          take(EV_DONE, e, ok);
          if (ok) begin
            chk("done_window_len", busy_cnt, e.len);
            chk("done_valve_closed", bus_if.valve, 0);
          end
        end
        if (prev_err == 2'b00 && bus_if.err != 2'b00) begin
          take(EV_FAULT, e, ok);
          if (ok) begin
            chk("fault_code", bus_if.err, e.errv);
            chk("fault_valve_closed", bus_if.valve, 0);
          end
        end
        if (prev_err != 2'b00 && bus_if.err == 2'b00) begin
          take(EV_CLEAR, e, ok);
        end
        if (bus_if.busy && !prev_busy) begin
          take(EV_GRANT, e, ok);
          if (ok) begin
            vexp = 8'(e.vf) << (2 * e.zone);
            chk("grant_zone", bus_if.active_zone, e.zone);
            chk("grant_valve", bus_if.valve, vexp);
            if (e.len >= 0) chk("grant_spacing", idle_cnt, e.len);
          end
          busy_cnt = 1;
        end else if (bus_if.busy) begin
          busy_cnt++;
        end
        if (!bus_if.busy && prev_busy) idle_cnt = 1;
        else if (!bus_if.busy) idle_cnt++;
        prev_busy = bus_if.busy;
        prev_err  = bus_if.err;
      end
    end
  end

  // Stimulus: directed scenarios with expected events queued up front.
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus_if.req = 8'h00;
    bus_if.level = 2'b10;
    bus_if.pump_ok = 1'b1;
    bus_if.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valve", bus_if.valve, 0);
    chk("reset_busy", bus_if.busy, 0);
    chk("reset_done", bus_if.done, 0);
    chk("reset_err", bus_if.err, 0);
    chk("reset_zone", bus_if.active_zone, 0);
    reset = 1'b1;

    // Round-robin with every zone requesting both valves.
    expect_ev(EV_GRANT, 0, 3, -1, 0); expect_ev(EV_DONE, 0, 0, 4, 0);
    expect_ev(EV_GRANT, 1, 3, 3, 0);  expect_ev(EV_DONE, 0, 0, 4, 0);
    expect_ev(EV_GRANT, 2, 3, 3, 0);  expect_ev(EV_DONE, 0, 0, 4, 0);
    expect_ev(EV_GRANT, 3, 3, 3, 0);  expect_ev(EV_DONE, 0, 0, 4, 0);
    expect_ev(EV_GRANT, 0, 3, 3, 0);  expect_ev(EV_DONE, 0, 0, 4, 0);
    bus_if.req = 8'hFF;
    for (int i = 0; i < 5; i++) wait_done(20);
    bus_if.req = 8'h00;
    repeat (4) @(negedge clk);

    // Single zone 1, valve A: two full windows back to back.
    expect_ev(EV_GRANT, 1, 1, -1, 0); expect_ev(EV_DONE, 0, 0, 4, 0);
    expect_ev(EV_GRANT, 1, 1, 3, 0);  expect_ev(EV_DONE, 0, 0, 4, 0);
    bus_if.req = 8'b0000_0100;
    wait_done(20);
    wait_done(20);
    bus_if.req = 8'h00;
    repeat (4) @(negedge clk);

    // Tank empty during WATER, then recovery only with err_clr.
    expect_ev(EV_GRANT, 3, 2, -1, 0);
    expect_ev(EV_FAULT, 0, 0, 0, 1);
    bus_if.req = 8'b1000_0000;
    wait_busy(10);
    bus_if.level = 2'b00;
    @(negedge clk);
    bus_if.level = 2'b10;
    repeat (3) @(negedge clk);
    chk("fault_sticky_err", bus_if.err, 1);
    chk("fault_sticky_valve", bus_if.valve, 0);
    expect_ev(EV_CLEAR, 0, 0, 0, 0);
    expect_ev(EV_GRANT, 3, 2, -1, 0);
    bus_if.err_clr = 1'b1;
    @(negedge clk);
    chk("clear_err", bus_if.err, 0);
    chk("clear_idle_busy", bus_if.busy, 0);
    bus_if.err_clr = 1'b0;
    @(negedge clk);
    chk("regrant_after_clear", bus_if.busy, 1);

    // Pump fault; err_clr is refused while the pump is still bad.
    expect_ev(EV_FAULT, 0, 0, 0, 2);
    bus_if.pump_ok = 1'b0;
    @(negedge clk);
    bus_if.err_clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("clr_blocked_by_pump", bus_if.err, 2);
    expect_ev(EV_CLEAR, 0, 0, 0, 0);
    bus_if.pump_ok = 1'b1;
    bus_if.req = 8'h00;
    @(negedge clk);
    bus_if.err_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Early release of zone 2 after two WATER cycles.
    expect_ev(EV_GRANT, 2, 3, -1, 0);
    expect_ev(EV_DONE, 0, 0, 2, 0);
    bus_if.req = 8'b0011_0000;
    wait_busy(10);
    @(negedge clk);
    bus_if.req = 8'h00;
    wait_done(10);
    repeat (4) @(negedge clk);

    // Low tank blocks grants but does not cut a running window short.
    bus_if.level = 2'b01;
    bus_if.req = 8'hFF;
    repeat (20) @(negedge clk);
    chk("low_level_no_grant", bus_if.busy, 0);
    chk("low_level_valve", bus_if.valve, 0);
    expect_ev(EV_GRANT, 3, 3, -1, 0);
    expect_ev(EV_DONE, 0, 0, 4, 0);
    bus_if.level = 2'b10;
    wait_busy(10);
    bus_if.level = 2'b01;
    wait_done(20);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-WATER; arbitration restarts at zone 0.
    expect_ev(EV_GRANT, 0, 3, -1, 0);
    bus_if.level = 2'b10;
    wait_busy(10);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_valve", bus_if.valve, 0);
    chk("async_reset_busy", bus_if.busy, 0);
    chk("async_reset_err", bus_if.err, 0);
    @(negedge clk);
    reset = 1'b1;
    expect_ev(EV_GRANT, 0, 3, -1, 0);
    expect_ev(EV_DONE, 0, 0, 4, 0);
    wait_busy(10);
    wait_done(20);
    bus_if.req = 8'h00;
    repeat (6) @(negedge clk);

    chk("events_outstanding", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
